// File: rtl/divisao_pkg.sv
// ============================================================================
// divisao_pkg : shared FSM encoding and default widths for the sequential divider
// Rev 1.0
// ============================================================================
`default_nettype none

package divisao_pkg;

    localparam int LARG_DIVIDENDO_PADRAO = 16;
    localparam int LARG_DIVISOR_PADRAO   = 8;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // Counter must be able to hold the value n itself.
    function automatic int larg_contador(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/divisao_sequencial_if.sv
// ============================================================================
// divisao_sequencial_if : operand/result bundle of the sequential divider
// Rev 1.0
// ============================================================================
`default_nettype none

interface divisao_sequencial_if
    import divisao_pkg::*;
#(
    parameter int LARG_DIVIDENDO = LARG_DIVIDENDO_PADRAO,
    parameter int LARG_DIVISOR   = LARG_DIVISOR_PADRAO
);
    logic                      inicio;
    logic [LARG_DIVIDENDO-1:0] dividendo;
    logic                      sinal_dividendo;
    logic [LARG_DIVISOR-1:0]   divisor;
    logic                      sinal_divisor;
    logic [LARG_DIVIDENDO-1:0] quociente;
    logic                      sinal_quociente;
    logic [LARG_DIVISOR-1:0]   resto;
    logic                      sinal_resto;
    logic                      ocupado;
    logic                      pronto;
    logic                      erro_div_zero;

    modport master (
        output inicio, dividendo, sinal_dividendo, divisor, sinal_divisor,
        input  quociente, sinal_quociente, resto, sinal_resto,
        input  ocupado, pronto, erro_div_zero
    );

    modport slave (
        input  inicio, dividendo, sinal_dividendo, divisor, sinal_divisor,
        output quociente, sinal_quociente, resto, sinal_resto,
        output ocupado, pronto, erro_div_zero
    );

endinterface

`default_nettype wire

// File: rtl/divisao_sequencial_passo_restauracao.sv
// ============================================================================
// passo_restauracao : one shift-compare-subtract step of restoring division
// Rev 1.0
// ============================================================================
`default_nettype none

module passo_restauracao
    import divisao_pkg::*;
#(
    parameter int LARG = LARG_DIVISOR_PADRAO
) (
    input  logic [LARG:0]   parcial_i,
    input  logic            bit_i,
    input  logic [LARG-1:0] divisor_i,
    output logic [LARG:0]   parcial_o,
    output logic            bit_q_o
);

    logic [LARG+1:0] w_desloc;
    logic [LARG:0]   w_dif;

    // Partial remainder stays below the divisor, so the shifted value fits LARG+1 bits
    // and the top bit only matters for the compare.
    assign w_desloc  = {parcial_i, bit_i};
    assign bit_q_o   = (w_desloc >= {2'b00, divisor_i});
    assign w_dif     = w_desloc[LARG:0] - {1'b0, divisor_i};
    assign parcial_o = bit_q_o ? w_dif : w_desloc[LARG:0];

endmodule

`default_nettype wire

// File: rtl/divisao_sequencial.sv
// ============================================================================
// divisao_sequencial : sign-magnitude sequential restoring divider, 1 bit/cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module divisao_sequencial
    import divisao_pkg::*;
#(
    parameter int LARG_DIVIDENDO = LARG_DIVIDENDO_PADRAO,
    parameter int LARG_DIVISOR   = LARG_DIVISOR_PADRAO
) (
    input  logic                 clk,
    input  logic                 rst,
    divisao_sequencial_if.slave  bus
);

    localparam int                  LARG_CNT = larg_contador(LARG_DIVIDENDO);
    localparam logic [LARG_CNT-1:0] CNT_FIM  = LARG_CNT'(LARG_DIVIDENDO);

    estado_t                   estado_q,  estado_d;
    logic [LARG_CNT-1:0]       cnt_q,     cnt_d;
    logic [LARG_DIVIDENDO-1:0] acc_q,     acc_d;
    logic [LARG_DIVISOR:0]     parcial_q, parcial_d;
    logic [LARG_DIVISOR-1:0]   divisor_q, divisor_d;
    logic                      sdd_q,     sdd_d;
    logic                      sdv_q,     sdv_d;
    logic [LARG_DIVIDENDO-1:0] quoc_q,    quoc_d;
    logic [LARG_DIVISOR-1:0]   resto_q,   resto_d;
    logic                      squoc_q,   squoc_d;
    logic                      sresto_q,  sresto_d;
    logic                      erro_q,    erro_d;

    logic [LARG_DIVISOR:0]     w_parcial;
    logic                      w_bit_q;

    passo_restauracao #(
        .LARG (LARG_DIVISOR)
    ) u_passo (
        .parcial_i (parcial_q),
        .bit_i     (acc_q[LARG_DIVIDENDO-1]),
        .divisor_i (divisor_q),
        .parcial_o (w_parcial),
        .bit_q_o   (w_bit_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            cnt_q     <= '0;
            acc_q     <= '0;
            parcial_q <= '0;
            divisor_q <= '0;
            sdd_q     <= 1'b0;
            sdv_q     <= 1'b0;
            quoc_q    <= '0;
            resto_q   <= '0;
            squoc_q   <= 1'b0;
            sresto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            parcial_q <= parcial_d;
            divisor_q <= divisor_d;
            sdd_q     <= sdd_d;
            sdv_q     <= sdv_d;
            quoc_q    <= quoc_d;
            resto_q   <= resto_d;
            squoc_q   <= squoc_d;
            sresto_q  <= sresto_d;
            erro_q    <= erro_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        parcial_d = parcial_q;
        divisor_d = divisor_q;
        sdd_d     = sdd_q;
        sdv_d     = sdv_q;
        quoc_d    = quoc_q;
        resto_d   = resto_q;
        squoc_d   = squoc_q;
        sresto_d  = sresto_q;
        erro_d    = erro_q;

        case (estado_q)
            OCIOSO: begin
                if (bus.inicio) begin
                    acc_d     = bus.dividendo;
                    divisor_d = bus.divisor;
                    sdd_d     = bus.sinal_dividendo;
                    sdv_d     = bus.sinal_divisor;
                    parcial_d = '0;
                    cnt_d     = '0;
                    if (bus.divisor == '0) begin
                        estado_d = FIM;
                        quoc_d   = '0;
                        resto_d  = '0;
                        squoc_d  = 1'b0;
                        sresto_d = 1'b0;
                        erro_d   = 1'b1;
                    end else begin
                        estado_d = CALCULA;
                    end
                end
            end

            CALCULA: begin
                // Dividend shifts out MSB-first while quotient bits shift in at the bottom.
                acc_d     = {acc_q[LARG_DIVIDENDO-2:0], w_bit_q};
                parcial_d = w_parcial;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_d == CNT_FIM) begin
                    estado_d = FIM;
                    quoc_d   = acc_d;
                    resto_d  = w_parcial[LARG_DIVISOR-1:0];
                    squoc_d  = (sdd_q ^ sdv_q) & (acc_d != '0);
                    sresto_d = sdd_q & (w_parcial[LARG_DIVISOR-1:0] != '0);
                    erro_d   = 1'b0;
                end
            end

            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    assign bus.quociente       = quoc_q;
    assign bus.resto           = resto_q;
    assign bus.sinal_quociente = squoc_q;
    assign bus.sinal_resto     = sresto_q;
    assign bus.erro_div_zero   = erro_q;
    assign bus.ocupado         = (estado_q != OCIOSO);
    assign bus.pronto          = (estado_q == FIM);

endmodule

`default_nettype wire

// File: tb/tb_divisao_sequencial.sv
// ============================================================================
// tb_divisao_sequencial : directed self-checking bench for divisao_sequencial
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_divisao_sequencial;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    divisao_sequencial_if #(.LARG_DIVIDENDO(16), .LARG_DIVISOR(8)) bus ();

    divisao_sequencial #(
        .LARG_DIVIDENDO (16),
        .LARG_DIVISOR   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            failures++;
            $display("FAIL %s: obtido=%0d esperado=%0d", tag, obtido, esperado);
        end
    endtask

    // Drives operands with inicio and returns #1 after the accepting edge (cycle 1).
    task automatic aceita(input logic [15:0] dd, input logic sd, input logic [7:0] dv, input logic sv);
        bus.dividendo       = dd;
        bus.sinal_dividendo = sd;
        bus.divisor         = dv;
        bus.sinal_divisor   = sv;
        bus.inicio          = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
    endtask

    task automatic aguarda_pronto(input int inicio_ciclo, output int ciclo);
        ciclo = inicio_ciclo;
        while (bus.pronto !== 1'b1 && ciclo < 40) begin
            @(posedge clk);
            #1;
            ciclo++;
        end
    endtask

    // After pronto: one more edge must bring the FSM back to idle; leaves time at a negedge.
    task automatic finaliza(input string tag);
        @(posedge clk);
        #1;
        verifica({tag, "_pronto_1ciclo"}, 32'(bus.pronto), 32'd0);
        verifica({tag, "_ocioso"}, 32'(bus.ocupado), 32'd0);
        @(negedge clk);
    endtask

    task automatic divide(input string tag, input logic [15:0] dd, input logic sd,
                          input logic [7:0] dv, input logic sv, input int lat_esp);
        int c;
        aceita(dd, sd, dv, sv);
        aguarda_pronto(1, c);
        verifica({tag, "_latencia"}, 32'(c), 32'(lat_esp));
        finaliza(tag);
    endtask

    task automatic confere(input string tag, input int q, input logic sq, input int r,
                           input logic sr, input logic e);
        verifica({tag, "_quoc"},  32'(bus.quociente),       32'(q));
        verifica({tag, "_squoc"}, 32'(bus.sinal_quociente), 32'(sq));
        verifica({tag, "_resto"}, 32'(bus.resto),           32'(r));
        verifica({tag, "_sresto"},32'(bus.sinal_resto),     32'(sr));
        verifica({tag, "_erro"},  32'(bus.erro_div_zero),   32'(e));
    endtask

    initial begin
        int c;
        int vistos;
        checks   = 0;
        failures = 0;
        bus.inicio          = 1'b0;
        bus.dividendo       = '0;
        bus.sinal_dividendo = 1'b0;
        bus.divisor         = '0;
        bus.sinal_divisor   = 1'b0;
        rst = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        verifica("rst_quoc",    32'(bus.quociente), 32'd0);
        verifica("rst_resto",   32'(bus.resto),     32'd0);
        verifica("rst_ocupado", 32'(bus.ocupado),   32'd0);
        verifica("rst_pronto",  32'(bus.pronto),    32'd0);
        verifica("rst_erro",    32'(bus.erro_div_zero), 32'd0);

        // Start on the very first edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        divide("p100_p7", 16'd100, 1'b0, 8'd7, 1'b0, 17);
        confere("p100_p7", 14, 1'b0, 2, 1'b0, 1'b0);

        divide("m100_p7", 16'd100, 1'b1, 8'd7, 1'b0, 17);
        confere("m100_p7", 14, 1'b1, 2, 1'b1, 1'b0);

        divide("p100_m7", 16'd100, 1'b0, 8'd7, 1'b1, 17);
        confere("p100_m7", 14, 1'b1, 2, 1'b0, 1'b0);

        divide("max_1", 16'd65535, 1'b0, 8'd1, 1'b0, 17);
        confere("max_1", 65535, 1'b0, 0, 1'b0, 1'b0);

        divide("p3_p200", 16'd3, 1'b0, 8'd200, 1'b0, 17);
        confere("p3_p200", 0, 1'b0, 3, 1'b0, 1'b0);

        divide("m7_m2", 16'd7, 1'b1, 8'd2, 1'b1, 17);
        confere("m7_m2", 3, 1'b0, 1, 1'b1, 1'b0);

        divide("div_zero", 16'd5, 1'b0, 8'd0, 1'b0, 1);
        confere("div_zero", 0, 1'b0, 0, 1'b0, 1'b1);

        divide("p9_p3", 16'd9, 1'b0, 8'd3, 1'b0, 17);
        confere("p9_p3", 3, 1'b0, 0, 1'b0, 1'b0);

        divide("m0_m3", 16'd0, 1'b1, 8'd3, 1'b1, 17);
        confere("m0_m3", 0, 1'b0, 0, 1'b0, 1'b0);

        // New request and operand change mid-run must be ignored.
        aceita(16'd100, 1'b0, 8'd7, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.inicio          = 1'b1;
        bus.dividendo       = 16'd50;
        bus.sinal_dividendo = 1'b1;
        bus.divisor         = 8'd3;
        bus.sinal_divisor   = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        aguarda_pronto(6, c);
        verifica("ignora_latencia", 32'(c), 32'd17);
        confere("ignora", 14, 1'b0, 2, 1'b0, 1'b0);
        finaliza("ignora");

        // Abort at cycle 8 with an asynchronous reset.
        aceita(16'd100, 1'b0, 8'd7, 1'b0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        verifica("abort_quoc",    32'(bus.quociente), 32'd0);
        verifica("abort_resto",   32'(bus.resto),     32'd0);
        verifica("abort_ocupado", 32'(bus.ocupado),   32'd0);
        verifica("abort_pronto",  32'(bus.pronto),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        vistos = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.pronto === 1'b1) vistos++;
        end
        verifica("abort_sem_pronto", 32'(vistos), 32'd0);
        @(negedge clk);
        divide("pos_abort", 16'd200, 1'b1, 8'd9, 1'b0, 17);
        confere("pos_abort", 22, 1'b1, 2, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/divisao_sequencial.md
DIVISAO_SEQUENCIAL -- requirements
Module: divisao_sequencial

Interface
REQ-001 SHALL have parameter LARG_DIVIDENDO, default 16, dividend and quotient magnitude width.
REQ-002 SHALL have parameter LARG_DIVISOR, default 8, divisor and remainder magnitude width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port inicio  input  1  start request, sampled on clk.
REQ-006 SHALL have port dividendo  input  LARG_DIVIDENDO  dividend magnitude.
REQ-007 SHALL have port sinal_dividendo  input  1  dividend sign, 1 = negative.
REQ-008 SHALL have port divisor  input  LARG_DIVISOR  divisor magnitude.
REQ-009 SHALL have port sinal_divisor  input  1  divisor sign, 1 = negative.
REQ-010 SHALL have port quociente  output  LARG_DIVIDENDO  quotient magnitude, registered.
REQ-011 SHALL have port sinal_quociente  output  1  quotient sign, registered.
REQ-012 SHALL have port resto  output  LARG_DIVISOR  remainder magnitude, registered.
REQ-013 SHALL have port sinal_resto  output  1  remainder sign, registered.
REQ-014 SHALL have port ocupado  output  1  high while a division is in progress.
REQ-015 SHALL have port pronto  output  1  one-cycle pulse, results valid.
REQ-016 SHALL have port erro_div_zero  output  1  divisor was zero for the last accepted operation.

Function
REQ-017 SHALL implement FSM states OCIOSO, CALCULA, FIM; OCIOSO->CALCULA on inicio=1 with divisor!=0; OCIOSO->FIM on inicio=1 with divisor==0; CALCULA->FIM when iteration counter reaches LARG_DIVIDENDO; FIM->OCIOSO unconditionally.
REQ-018 SHALL capture dividendo, divisor and both signs on the accepting edge; later input changes do not affect the operation.
REQ-019 SHALL ignore inicio in CALCULA and FIM (no restart, no queueing).
REQ-020 SHALL perform unsigned restoring division on magnitudes, one quotient bit per cycle, MSB first, using a LARG_DIVISOR+1-bit partial remainder.
REQ-021 SHALL hold ocupado=1 in CALCULA and FIM, 0 in OCIOSO.
REQ-022 SHALL assert pronto for exactly one cycle in FIM: LARG_DIVIDENDO+1 cycles (17 at default) after the accepting edge for nonzero divisor; 1 cycle after it for zero divisor.
REQ-023 SHALL update quociente, resto, both signs and erro_div_zero on entry to FIM and hold them until the next FIM entry or reset.
REQ-024 SHALL set sinal_quociente = sinal_dividendo XOR sinal_divisor; sinal_resto = sinal_dividendo (truncating division).
REQ-025 SHALL force a sign to 0 whenever its magnitude is 0 (no negative zero).
REQ-026 SHALL on divisor==0 output quociente=0, resto=0, both signs 0, erro_div_zero=1; otherwise erro_div_zero=0.
REQ-027 SHALL accept a new inicio in the OCIOSO cycle immediately following FIM (back-to-back throughput of one division per LARG_DIVIDENDO+2 cycles).

Reset
REQ-028 SHALL, on rst=1 at any time including mid-division, asynchronously force state OCIOSO, counter 0, all outputs 0; the aborted operation produces no pronto.
REQ-029 SHALL accept inicio on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL place FSM state encoding and default width constants in shared package divisao_pkg.
REQ-031 SHALL isolate one shift-compare-subtract step as combinational sub-module passo_restauracao; counter, FSM and registers stay in the top.

Verification
REQ-032 SHALL test +100 / +7 -> after 17 cycles pronto, quociente=14, resto=2, both signs 0, erro_div_zero=0.
REQ-033 SHALL test -100 / +7 -> quociente=14 sinal_quociente=1, resto=2 sinal_resto=1; and +100 / -7 -> quociente=14 sinal_quociente=1, resto=2 sinal_resto=0.
REQ-034 SHALL test 65535 / 1 -> quociente=65535, resto=0; and 3 / 200 -> quociente=0 sinal 0, resto=3.
REQ-035 SHALL test 5 / 0 -> pronto 1 cycle after acceptance, erro_div_zero=1, quociente=0, resto=0; next division 9/3 -> erro_div_zero=0, quociente=3.
REQ-036 SHALL test -0 / -3 -> quociente=0, resto=0, sinal_quociente=0, sinal_resto=0.
REQ-037 SHALL test inicio pulsed and operands changed at cycle 5 of 100/7 -> ignored, result still 14 r 2; rst asserted at cycle 8 of a second run -> outputs 0 immediately, no pronto, new run after release completes correctly.
